// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: instruction and PC widths,
// the NOP encoding, the PC increment, the IF/ID payload record and two small
// address helpers used by the PC logic.
package fetch_stage_pkg;

    localparam int INST_W = 32;
    localparam int PC_W   = 32;

    // An all-zero word is the pipeline bubble. Squashed and out-of-range
    // fetches insert it.
    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;

    // The PC advances by one 32-bit word per fetch.
    localparam logic [PC_W-1:0] PC_INC = 32'd4;

    // Payload that travels from IF to ID.
    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc4;
        logic              valid;
    } ifid_t;

    // Contents of IF/ID after reset, a flush or an out-of-range fetch.
    localparam ifid_t IFID_BUBBLE = '{inst: NOP_INST, pc4: '0, valid: 1'b0};

    // Sequential PC. The sum is taken modulo 2^32, so the last word address
    // wraps back to zero.
    function automatic logic [PC_W-1:0] pc_plus_inc(input logic [PC_W-1:0] pc);
        return pc + PC_INC;
    endfunction

    // Returns 1 when every byte of the word at pc lies below mem_size.
    // The comparison is done one bit wider. This keeps a small mem_size from
    // underflowing. It also stops a PC near the top of the address space from
    // wrapping into range.
    function automatic logic word_in_range(input logic [PC_W-1:0] pc,
                                           input logic [PC_W-1:0] mem_size);
        logic [PC_W:0] word_end;
        word_end = {1'b0, pc} + {1'b0, PC_INC};
        return word_end <= {1'b0, mem_size};
    endfunction

    // Returns 1 when a jump or branch target is not word aligned.
    function automatic logic target_misaligned(input logic [PC_W-1:0] target);
        return target[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register.
// Priority at each edge: flush loads a bubble, stall holds, otherwise capture.
// The out-of-range substitution is decided upstream in fetch_stage, which
// presents a bubble on fetch_word when the word is not in memory.
module if_id_reg
    import fetch_stage_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  stall,
    input  logic  flush,
    input  ifid_t fetch_word,
    output ifid_t id_word
);

    // Register the IF/ID payload: flush > stall > capture.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
        if (rst) begin
            id_word <= IFID_BUBBLE;
        end else if (flush) begin
            id_word <= IFID_BUBBLE;
        end else if (!stall) begin
            // NOTE: leaving id_word unassigned on stall is a clocked hold, not a latch, because this is always_ff.
            id_word <= fetch_word;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage.
// The block holds the PC register, the next-PC mux and the memory range check.
// It drives the instruction memory address straight from the PC. It feeds the
// IF/ID register with either the returned word or a bubble when the word lies
// outside memory.
// fetch_err is sticky until reset. It is set by a misaligned redirect target,
// or by a capture cycle whose PC is out of range.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [PC_W-1:0] MEM_SIZE = 32'd511
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              redirect,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic [PC_W-1:0]   imem_pc,
    input  logic [INST_W-1:0] imem_inst,
    output logic [INST_W-1:0] ifid_inst,
    output logic [PC_W-1:0]   ifid_pc4,
    output logic              ifid_valid,
    output logic              fetch_err
);

    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_seq;
    logic [PC_W-1:0] pc_next;
    logic            capture;
    logic            in_range;
    logic            err_set;
    ifid_t           fetch_word;
    ifid_t           id_word;

    // The memory address is the PC register itself, with no logic in between,
    // so the memory lookup gets the whole cycle.
    assign imem_pc  = pc;
    assign pc_seq   = pc_plus_inc(pc);
    assign in_range = word_in_range(pc, MEM_SIZE);

    // IF/ID takes a new word only when nothing squashes or holds it. The range
    // check matters only on those cycles.
    assign capture  = !flush && !stall;

    assign err_set  = (redirect && target_misaligned(redirect_pc))
                   || (capture && !in_range);

    // Next-PC mux: redirect wins over stall; flush alone leaves the PC advancing.
    always_comb begin
        pc_next = pc_seq;
        if (redirect) begin
            pc_next = {redirect_pc[PC_W-1:2], 2'b00};
        end else if (stall) begin
            pc_next = pc;
        end
    end

    // Select the IF/ID payload: the fetched word, or a bubble when the word at
    // the PC is not fully inside memory.
    always_comb begin
        fetch_word = IFID_BUBBLE;
        if (in_range) begin
            fetch_word.inst  = imem_inst;
            fetch_word.pc4   = pc_seq;
            fetch_word.valid = 1'b1;
        end
    end

    // PC register, forced to RESET_PC asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

    // Sticky fault flag: once set, only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_err <= 1'b0;
        end else if (err_set) begin
            fetch_err <= 1'b1;
        end
    end

    if_id_reg u_if_id_reg (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .flush      (flush),
        .fetch_word (fetch_word),
        .id_word    (id_word)
    );

    assign ifid_inst  = id_word.inst;
    assign ifid_pc4   = id_word.pc4;
    assign ifid_valid = id_word.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage.
// A directed vector table covers the reference scenarios and the boundaries.
// A hand-written sequence covers an asynchronous reset during a stall. The
// randomized phase is checked against a rule-level model of the fetch stage.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] MEM_SIZE  = 32'd511;
    localparam int          MEM_WORDS = 128;
    localparam logic [31:0] OOR_WORD  = 32'hDEAD_BEEF;
    localparam int          RAND_CYCLES = 1500;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] imem_pc;
    logic [31:0] imem_inst;
    logic [31:0] ifid_inst;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic        fetch_err;

    logic [31:0] mem [MEM_WORDS];

    int total = 0;
    int bad   = 0;

    // Model state for the randomized phase.
    logic [31:0] m_pc;
    logic [31:0] m_inst;
    logic [31:0] m_pc4;
    logic        m_valid;
    logic        m_err;
    logic        m_pc4_care;

    typedef struct {
        logic        stall;
        logic        flush;
        logic        redirect;
        logic [31:0] rpc;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] pc4;
        logic        valid;
        logic        err;
        logic        pc4_care;
    } vec_t;

    vec_t vecs[20];

    fetch_stage #(
        .RESET_PC (RESET_PC),
        .MEM_SIZE (MEM_SIZE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .flush       (flush),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_pc     (imem_pc),
        .imem_inst   (imem_inst),
        .ifid_inst   (ifid_inst),
        .ifid_pc4    (ifid_pc4),
        .ifid_valid  (ifid_valid),
        .fetch_err   (fetch_err)
    );

    always #5 clk = ~clk;

    // Combinational instruction memory; addresses past the end return a marker word.
    always_comb begin
        imem_inst = OOR_WORD;
        if (longint'(imem_pc) + 4 <= longint'(MEM_SIZE)) imem_inst = mem[imem_pc[8:2]];
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic st, input logic fl, input logic rd, input logic [31:0] rpc,
                                input logic [31:0] pc, input logic [31:0] inst, input logic [31:0] pc4,
                                input logic valid, input logic err, input logic pc4_care);
        vec_t v;
        v.stall = st; v.flush = fl; v.redirect = rd; v.rpc = rpc;
        v.pc = pc; v.inst = inst; v.pc4 = pc4; v.valid = valid; v.err = err; v.pc4_care = pc4_care;
        return v;
    endfunction

    task automatic apply_vec(input int idx);
        vec_t v;
        v = vecs[idx];
        stall = v.stall; flush = v.flush; redirect = v.redirect; redirect_pc = v.rpc;
        step();
        check($sformatf("vec%0d imem_pc", idx), imem_pc, v.pc);
        check($sformatf("vec%0d ifid_inst", idx), ifid_inst, v.inst);
        if (v.pc4_care) check($sformatf("vec%0d ifid_pc4", idx), ifid_pc4, v.pc4);
        check($sformatf("vec%0d ifid_valid", idx), {31'b0, ifid_valid}, {31'b0, v.valid});
        check($sformatf("vec%0d fetch_err", idx), {31'b0, fetch_err}, {31'b0, v.err});
    endtask

    task automatic check_cleared(input string tag);
        check({tag, " imem_pc"}, imem_pc, RESET_PC);
        check({tag, " ifid_inst"}, ifid_inst, 32'h0);
        check({tag, " ifid_pc4"}, ifid_pc4, 32'h0);
        check({tag, " ifid_valid"}, {31'b0, ifid_valid}, 32'h0);
        check({tag, " fetch_err"}, {31'b0, fetch_err}, 32'h0);
    endtask

    task automatic model_reset();
        m_pc = RESET_PC; m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_err = 1'b0; m_pc4_care = 1'b1;
    endtask

    // One clock edge of the fetch stage, expressed as the architectural rules.
    task automatic model_edge(input logic st, input logic fl, input logic rd, input logic [31:0] rpc);
        bit capture;
        bit word_ok;
        capture = !fl && !st;
        word_ok = (longint'(m_pc) + 4) <= longint'(MEM_SIZE);
        if (rd && (rpc % 4 != 0)) m_err = 1'b1;
        if (capture && !word_ok) m_err = 1'b1;
        if (fl) begin
            m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_pc4_care = 1'b1;
        end else if (!st) begin
            if (word_ok) begin
                m_inst = mem[m_pc / 4]; m_pc4 = m_pc + 32'd4; m_valid = 1'b1; m_pc4_care = 1'b1;
            end else begin
                m_inst = 32'h0; m_valid = 1'b0; m_pc4_care = 1'b0;
            end
        end
        if (rd) m_pc = rpc - (rpc % 4);
        else if (!st) m_pc = m_pc + 32'd4;
    endtask

    task automatic check_model(input string tag);
        check({tag, " imem_pc"}, imem_pc, m_pc);
        check({tag, " ifid_inst"}, ifid_inst, m_inst);
        if (m_pc4_care) check({tag, " ifid_pc4"}, ifid_pc4, m_pc4);
        check({tag, " ifid_valid"}, {31'b0, ifid_valid}, {31'b0, m_valid});
        check({tag, " fetch_err"}, {31'b0, fetch_err}, {31'b0, m_err});
    endtask

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = 32'h1000_0000 + i;

        //             st fl rd rpc            pc            inst          pc4           v  e  pc4?
        vecs[0]  = mk(0, 0, 0, 32'h0,        32'h4,        32'h1000_0000, 32'h4,        1, 0, 1);
        vecs[1]  = mk(0, 0, 0, 32'h0,        32'h8,        32'h1000_0001, 32'h8,        1, 0, 1);
        vecs[2]  = mk(1, 0, 0, 32'h0,        32'h8,        32'h1000_0001, 32'h8,        1, 0, 1);
        vecs[3]  = mk(1, 0, 0, 32'h0,        32'h8,        32'h1000_0001, 32'h8,        1, 0, 1);
        vecs[4]  = mk(0, 0, 0, 32'h0,        32'hC,        32'h1000_0002, 32'hC,        1, 0, 1);
        vecs[5]  = mk(0, 1, 1, 32'h40,       32'h40,       32'h0,         32'h0,        0, 0, 1);
        vecs[6]  = mk(0, 0, 0, 32'h0,        32'h44,       32'h1000_0010, 32'h44,       1, 0, 1);
        vecs[7]  = mk(0, 0, 1, 32'h42,       32'h40,       32'h1000_0011, 32'h48,       1, 1, 1);
        vecs[8]  = mk(1, 0, 0, 32'h0,        32'h40,       32'h1000_0011, 32'h48,       1, 1, 1);
        vecs[9]  = mk(0, 0, 1, 32'h1F8,      32'h1F8,      32'h1000_0001, 32'h8,        1, 0, 1);
        vecs[10] = mk(0, 0, 0, 32'h0,        32'h1FC,      32'h1000_007E, 32'h1FC,      1, 0, 1);
        vecs[11] = mk(0, 0, 0, 32'h0,        32'h200,      32'h0,         32'h0,        0, 1, 0);
        vecs[12] = mk(0, 0, 0, 32'h0,        32'h204,      32'h0,         32'h0,        0, 1, 0);
        vecs[13] = mk(1, 1, 0, 32'h0,        32'h204,      32'h0,         32'h0,        0, 1, 1);
        vecs[14] = mk(1, 0, 1, 32'h10,       32'h10,       32'h0,         32'h0,        0, 1, 1);
        vecs[15] = mk(0, 0, 0, 32'h0,        32'h14,       32'h1000_0004, 32'h14,       1, 1, 1);
        vecs[16] = mk(0, 1, 0, 32'h0,        32'h18,       32'h0,         32'h0,        0, 1, 1);
        vecs[17] = mk(0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h1000_0006, 32'h1C,     1, 1, 1);
        vecs[18] = mk(0, 0, 0, 32'h0,        32'h0,        32'h0,         32'h0,        0, 1, 0);
        vecs[19] = mk(0, 0, 0, 32'h0,        32'h4,        32'h1000_0000, 32'h4,        1, 1, 1);

        // Power-on reset, released between edges.
        #3;
        check_cleared("reset");
        #5 rst = 1'b0;

        for (int i = 0; i <= 8; i++) apply_vec(i);

        // Asynchronous reset in the middle of a stall at PC 0x40.
        #2 rst = 1'b1;
        #1 check_cleared("async_rst");
        #2 rst = 1'b0;
        stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        step();
        check("post_rst imem_pc", imem_pc, 32'h4);
        check("post_rst ifid_inst", ifid_inst, 32'h1000_0000);
        check("post_rst ifid_pc4", ifid_pc4, 32'h4);
        check("post_rst ifid_valid", {31'b0, ifid_valid}, 32'h1);

        for (int i = 9; i < 20; i++) apply_vec(i);

        // Randomized phase against the reference model.
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
        stall = 1'b0; flush = 1'b0; redirect = 1'b0;
        #2 rst = 1'b1;
        #1 rst = 1'b0;
        model_reset();
        check_model("rnd_init");
        for (int cyc = 0; cyc < RAND_CYCLES; cyc++) begin
            logic st;
            logic fl;
            logic rd;
            logic [31:0] rpc;
            int sel;
            st = ($urandom_range(0, 3) == 0);
            fl = ($urandom_range(0, 6) == 0);
            rd = ($urandom_range(0, 6) == 0);
            sel = $urandom_range(0, 9);
            if (sel <= 5)      rpc = 32'($urandom_range(0, 127)) << 2;
            else if (sel == 6) rpc = 32'd480 + 32'($urandom_range(0, 31));
            else if (sel == 7) rpc = $urandom;
            else if (sel == 8) rpc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            else               rpc = (32'($urandom_range(0, 127)) << 2) | 32'($urandom_range(1, 3));
            if (!rd && (sel == 0)) rpc = 32'h0;
            stall = st; flush = fl; redirect = rd; redirect_pc = rpc;
            if ($urandom_range(0, 149) == 0) begin
                #2 rst = 1'b1;
                #1;
                model_reset();
                check_model($sformatf("rnd%0d async", cyc));
                #1 rst = 1'b0;
            end else begin
                step();
                model_edge(st, fl, rd, rpc);
                check_model($sformatf("rnd%0d", cyc));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
